// File: rtl/tribuf_port.sv
// Tri-state pad port: one-cycle registered drive bursts, then TURN_CYC dead cycles; reads sample the idle pad.
// Read latency 1; writes win over reads, non-accepted requests are ignored and must be held by the requester.
module tribuf_port #(
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  inout  wire  [WIDTH-1:0] pad
);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  localparam logic [3:0] TURN_LOAD = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       turn_cnt;
  logic [3:0]       turn_cnt_nxt;
  logic [WIDTH-1:0] drv;
  logic             wr_acc;
  logic             rd_acc;
  logic             oe;

  always_comb begin
    wr_ready     = !rst && (state != TURN);
    rd_ready     = !rst && (state == IDLE) && !wr_req;
    wr_acc       = wr_req && wr_ready;
    rd_acc       = rd_req && rd_ready;
    state_nxt    = state;
    turn_cnt_nxt = turn_cnt;
    case (state)
      IDLE: begin
        if (wr_acc) state_nxt = DRIVE;
      end
      DRIVE: begin
        // Back-to-back writes keep the bus driven; otherwise release and count dead cycles.
        if (!wr_acc) begin
          if (TURN_CYC == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt    = TURN;
            turn_cnt_nxt = TURN_LOAD;
          end
        end
      end
      TURN: begin
        if (turn_cnt == 4'd0) state_nxt = IDLE;
        else                  turn_cnt_nxt = turn_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      turn_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drv      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) drv <= wr_data;
      if (rd_acc) rd_data <= pad;
      rd_valid <= rd_acc;
    end
  end

  assign oe   = (state == DRIVE);
  assign busy = (state != IDLE);
  assign pad  = oe ? drv : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tribuf_port.sv
// Directed bench for tribuf_port: TURN_CYC=2 instance for the main cases, TURN_CYC=0 instance for the no-turnaround case.
module tb_tribuf_port;

  logic       clk = 1'b0;
  logic       rst;
  int         checks = 0;
  int         errors = 0;

  // TURN_CYC = 2 instance
  logic       wr_req, rd_req, wr_ready, rd_ready, rd_valid, busy;
  logic [7:0] wr_data, rd_data;
  logic       ext_oe;
  logic [7:0] ext_dat;
  wire  [7:0] pad;
  assign pad = ext_oe ? ext_dat : 8'bz;

  // TURN_CYC = 0 instance
  logic       q_wr_req, q_rd_req, q_wr_ready, q_rd_ready, q_rd_valid, q_busy;
  logic [7:0] q_wr_data, q_rd_data;
  logic       q_ext_oe;
  logic [7:0] q_ext_dat;
  wire  [7:0] q_pad;
  assign q_pad = q_ext_oe ? q_ext_dat : 8'bz;

  tribuf_port #(.WIDTH(8), .TURN_CYC(2)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .pad(pad)
  );

  tribuf_port #(.WIDTH(8), .TURN_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .wr_req(q_wr_req), .wr_data(q_wr_data), .wr_ready(q_wr_ready),
    .rd_req(q_rd_req), .rd_ready(q_rd_ready), .rd_data(q_rd_data), .rd_valid(q_rd_valid),
    .busy(q_busy), .pad(q_pad)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Released-pad checks rely on the bench driving a probe value: a DUT still driving would corrupt it.
  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
    ext_oe = 1'b1; ext_dat = 8'h96;
    q_wr_req = 1'b0; q_rd_req = 1'b0; q_wr_data = 8'h00;
    q_ext_oe = 1'b1; q_ext_dat = 8'h69;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_pad", pad, 8'h96);
    chk("rst_q_busy", q_busy, 1'b0);

    rst = 1'b0; #1;
    chk("idle_wr_ready", wr_ready, 1'b1);
    chk("idle_rd_ready", rd_ready, 1'b1);

    // Single write 0xA5
    wr_req = 1'b1; wr_data = 8'hA5; ext_oe = 1'b0; #1;
    chk("wr_blocks_rd_ready", rd_ready, 1'b0);
    step();
    wr_req = 1'b0; #1;
    chk("single_pad", pad, 8'hA5);
    chk("single_busy_d", busy, 1'b1);
    chk("single_wr_ready_d", wr_ready, 1'b1);
    step();
    ext_oe = 1'b1; ext_dat = 8'h5A; #1;
    chk("single_turn1_pad", pad, 8'h5A);
    chk("single_turn1_busy", busy, 1'b1);
    chk("single_turn1_wr_ready", wr_ready, 1'b0);
    chk("single_turn1_rd_ready", rd_ready, 1'b0);
    step();
    chk("single_turn2_busy", busy, 1'b1);
    chk("single_turn2_wr_ready", wr_ready, 1'b0);
    chk("single_turn2_pad", pad, 8'h5A);
    step();
    chk("single_idle_busy", busy, 1'b0);
    chk("single_idle_wr_ready", wr_ready, 1'b1);

    // Back-to-back writes 0x11, 0x22, 0x33
    ext_oe = 1'b0; wr_req = 1'b1; wr_data = 8'h11;
    step();
    chk("b2b_pad0", pad, 8'h11);
    wr_data = 8'h22;
    step();
    chk("b2b_pad1", pad, 8'h22);
    chk("b2b_busy1", busy, 1'b1);
    wr_data = 8'h33;
    step();
    chk("b2b_pad2", pad, 8'h33);
    wr_req = 1'b0;
    step();
    ext_oe = 1'b1; ext_dat = 8'h44; #1;
    chk("b2b_turn1_pad", pad, 8'h44);
    chk("b2b_turn1_wr_ready", wr_ready, 1'b0);
    step();
    chk("b2b_turn2_busy", busy, 1'b1);
    step();
    chk("b2b_idle_busy", busy, 1'b0);

    // Two consecutive reads
    ext_dat = 8'h3C; rd_req = 1'b1; #1;
    chk("rd_ready_idle", rd_ready, 1'b1);
    step();
    ext_dat = 8'hC3;
    chk("rd1_valid", rd_valid, 1'b1);
    chk("rd1_data", rd_data, 8'h3C);
    chk("rd1_busy", busy, 1'b0);
    step();
    rd_req = 1'b0;
    chk("rd2_valid", rd_valid, 1'b1);
    chk("rd2_data", rd_data, 8'hC3);
    step();
    chk("rd_done_valid", rd_valid, 1'b0);
    chk("rd_hold_data", rd_data, 8'hC3);

    // Simultaneous write and read: write wins, read waits for TURN to finish
    ext_oe = 1'b0; wr_req = 1'b1; wr_data = 8'h81; rd_req = 1'b1; #1;
    chk("both_rd_ready", rd_ready, 1'b0);
    chk("both_wr_ready", wr_ready, 1'b1);
    step();
    wr_req = 1'b0; #1;
    chk("both_pad", pad, 8'h81);
    chk("both_no_rd_valid", rd_valid, 1'b0);
    chk("both_drive_rd_ready", rd_ready, 1'b0);
    step();
    ext_oe = 1'b1; ext_dat = 8'h7E; #1;
    chk("both_turn1_rd_ready", rd_ready, 1'b0);
    chk("both_turn1_rd_valid", rd_valid, 1'b0);
    step();
    chk("both_turn2_rd_ready", rd_ready, 1'b0);
    step();
    chk("both_idle_rd_ready", rd_ready, 1'b1);
    chk("both_idle_rd_valid", rd_valid, 1'b0);
    step();
    rd_req = 1'b0;
    chk("both_rd_valid", rd_valid, 1'b1);
    chk("both_rd_data", rd_data, 8'h7E);

    // Reset mid-DRIVE
    ext_oe = 1'b0; wr_req = 1'b1; wr_data = 8'h5A;
    step();
    chk("rstd_pad", pad, 8'h5A);
    chk("rstd_busy", busy, 1'b1);
    rst = 1'b1; #1;
    chk("rstd_wr_ready", wr_ready, 1'b0);
    chk("rstd_rd_ready", rd_ready, 1'b0);
    step();
    ext_oe = 1'b1; ext_dat = 8'hA5; #1;
    chk("rstd_pad_released", pad, 8'hA5);
    chk("rstd_busy_after", busy, 1'b0);
    chk("rstd_rd_data", rd_data, 8'h00);
    chk("rstd_rd_valid", rd_valid, 1'b0);
    chk("rstd_wr_ready_hold", wr_ready, 1'b0);
    rst = 1'b0; wr_req = 1'b0;
    step();
    chk("rstd_recover_busy", busy, 1'b0);

    // TURN_CYC = 0: write then read on the next edge
    q_ext_oe = 1'b0; q_wr_req = 1'b1; q_wr_data = 8'hF0;
    step();
    q_wr_req = 1'b0; q_rd_req = 1'b1; #1;
    chk("t0_pad", q_pad, 8'hF0);
    chk("t0_busy", q_busy, 1'b1);
    chk("t0_drive_rd_ready", q_rd_ready, 1'b0);
    step();
    q_ext_oe = 1'b1; q_ext_dat = 8'h0F; #1;
    chk("t0_idle_busy", q_busy, 1'b0);
    chk("t0_idle_rd_ready", q_rd_ready, 1'b1);
    chk("t0_idle_wr_ready", q_wr_ready, 1'b1);
    chk("t0_pad_released", q_pad, 8'h0F);
    step();
    q_rd_req = 1'b0;
    chk("t0_rd_valid", q_rd_valid, 1'b1);
    chk("t0_rd_data", q_rd_data, 8'h0F);
    step();
    chk("t0_rd_valid_end", q_rd_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
